// File: rtl/lsu_mem_if_pkg.sv
// Shared types for the LSU/SRAM front end: size encoding, FSM states and the byte-lane mask helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Byte enables for an access of the given size starting at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// CPU request/response handshake plus SRAM port-B signals for lsu_mem_if.
interface lsu_mem_if_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_mem_if_lane_align.sv
// Combinational byte-lane steering for stores and field extraction/extension for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_dout,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Store side: replicate the right-justified data so every lane sees it
  always_comb begin
    st_be = lane_mask(st_size, st_lane);
    case (st_size)
      SZ_BYTE: st_data = {4{st_wdata[7:0]}};
      SZ_HALF: st_data = {2{st_wdata[15:0]}};
      default: st_data = st_wdata;
    endcase
  end

  // Load side: bring the addressed field down to bit 0, then extend
  always_comb begin
    shifted = ld_dout >> {ld_lane, 3'b000};
    case (ld_size)
      SZ_BYTE: begin
        if (ld_unsigned) begin
          ld_data = {24'd0, shifted[7:0]};
        end else begin
          ld_data = {{24{shifted[7]}}, shifted[7:0]};
        end
      end
      SZ_HALF: begin
        if (ld_unsigned) begin
          ld_data = {16'd0, shifted[15:0]};
        end else begin
          ld_data = {{16{shifted[15]}}, shifted[15:0]};
        end
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store front end for SRAM port B: one request at a time, byte-lane steering, one-cycle read absorb.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int          RAM_DEPTH = 2048,
  parameter int          ADDR_W    = $clog2(RAM_DEPTH),
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic         clka,
  input logic         rstb,
  lsu_mem_if_if.slave bus
);

  localparam logic [32:0] SPAN = 33'(4 * RAM_DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [32:0]       diff;
  logic [31:0]       offset;
  logic [1:0]        raw_lane;
  logic [1:0]        eff_lane;
  logic [ADDR_W-1:0] word_idx;
  logic              range_fault;
  logic              size_fault;
  logic              misalign;
  logic              fault;
  logic              accept;
  logic              req_ready;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [1:0]        ld_lane;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic [31:0]       ld_data;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  // Borrow out of the 33-bit subtract flags addresses below the SRAM window
  assign diff        = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign offset      = diff[31:0];
  assign raw_lane    = offset[1:0];
  assign word_idx    = offset[ADDR_W+1:2];
  assign range_fault = diff[32] || ({1'b0, offset} >= SPAN);
  assign size_fault  = (bus.req_size == SZ_ILL);
  assign fault       = range_fault | size_fault | misalign;

  // Misalignment policy: trap, or silently drop the low address bits
  always_comb begin
    misalign = 1'b0;
    eff_lane = raw_lane;
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_size)
      SZ_HALF: misalign = raw_lane[0];
      SZ_WORD: misalign = (raw_lane != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    case (bus.req_size)
      SZ_HALF: eff_lane = {raw_lane[1], 1'b0};
      SZ_WORD: eff_lane = 2'b00;
      default: eff_lane = raw_lane;
    endcase
`endif
  end

  lsu_lane_align u_align (
    .st_size    (bus.req_size),
    .st_lane    (eff_lane),
    .st_wdata   (bus.req_wdata),
    .st_be      (st_be),
    .st_data    (st_data),
    .ld_size    (ld_size),
    .ld_lane    (ld_lane),
    .ld_unsigned(ld_unsigned),
    .ld_dout    (bus.mem_dout),
    .ld_data    (ld_data)
  );

  // Next state and SRAM drive; everything held at zero while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_din   = 32'd0;
    if (rstb) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (bus.req_valid) begin
            accept = 1'b1;
            if (fault) begin
              state_nxt = RSP;
            end else if (bus.req_we) begin
              mem_en    = 1'b1;
              mem_addr  = word_idx;
              mem_we    = st_be;
              mem_din   = st_data;
              state_nxt = RSP;
            end else begin
              mem_en    = 1'b1;
              mem_addr  = word_idx;
              state_nxt = RD;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        RD: state_nxt = RSP;
        RSP: begin
          if (bus.resp_ready) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RSP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clka) begin
    if (rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lane, size and signedness of an accepted load, consumed in RD
  always_ff @(posedge clka) begin
    if (rstb) begin
      ld_lane     <= 2'b00;
      ld_size     <= SZ_BYTE;
      ld_unsigned <= 1'b0;
    end else if (accept) begin
      ld_lane     <= eff_lane;
      ld_size     <= bus.req_size;
      ld_unsigned <= bus.req_unsigned;
    end
  end

  // Response register: set at accept for stores/faults, from SRAM data in RD
  always_ff @(posedge clka) begin
    if (rstb) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= (state_nxt == RSP);
      if (accept && (fault || bus.req_we)) begin
        resp_rdata <= 32'd0;
        resp_err   <= fault;
      end else if (state == RD) begin
        resp_rdata <= ld_data;
        resp_err   <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_din    = mem_din;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = resp_rdata;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed vector table, hand sequences, and random traffic
// checked against a byte-array memory model.
module tb_lsu_mem_if;

  logic clka = 1'b0;
  logic rstb;
  int   tests;
  int   failed;

  lsu_mem_if_if #(.ADDR_W(11)) bus ();

  lsu_mem_if dut (
    .clka(clka),
    .rstb(rstb),
    .bus (bus)
  );

  always #5 clka = ~clka;

  // SRAM port B: registered read, byte-enabled write
  logic [31:0] ram [0:2047] = '{default: 32'h0};
  always @(posedge clka) begin
    if (bus.mem_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_we[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_din[8*i +: 8];
      end
      bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  // Reference model: plain byte-addressed memory of 4*2048 bytes
  logic [7:0] mdl [0:8191];

  function automatic logic mdl_fault(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (a >= 32'h0000_2000) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (s == 2'd1 && a[0]) return 1'b1;
    if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int ea_of(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd1) return int'(a & 32'hFFFF_FFFE);
    if (s == 2'd2) return int'(a & 32'hFFFF_FFFC);
    return int'(a);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int n = 1 << s;
    int ea = ea_of(a, s);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[ea + i];
    if (!u && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
    int n = 1 << s;
    int ea = ea_of(a, s);
    for (int i = 0; i < n; i++) mdl[ea + i] = wd[8*i +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction; samples the SRAM drive at accept and counts cycles to resp_valid
  logic        o_err, o_rdy, o_en;
  logic [31:0] o_rd, o_din;
  logic [3:0]  o_we;
  logic [10:0] o_ma;
  int          o_lat;

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clka);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    #1;
    o_rdy = bus.req_ready; o_en = bus.mem_en; o_we = bus.mem_we;
    o_ma = bus.mem_addr; o_din = bus.mem_din;
    @(negedge clka);
    bus.req_valid = 1'b0;
    o_lat = 1;
    while (bus.resp_valid !== 1'b1 && o_lat < 8) begin
      @(negedge clka);
      o_lat++;
    end
    o_err = bus.resp_err; o_rd = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    @(negedge clka);
    bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        x_err;
    logic [31:0] x_rd;
    logic        x_en;
    logic [3:0]  x_we;
    logic [10:0] x_ma;
    logic [31:0] x_din;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] hold_rd;
  logic        hold_err;
  int          w;
  logic        r_we, r_u, r_f;
  logic [1:0]  r_s;
  logic [31:0] r_a, r_wd, r_x;

  initial begin
    tests = 0; failed = 0;
    for (int i = 0; i < 8192; i++) mdl[i] = 8'h00;

    // Reset with a legal store pending: nothing may reach the SRAM
    rstb = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h1234_5678; bus.resp_ready = 1'b0;
    repeat (2) @(negedge clka);
    #1;
    chk("rst.req_ready", bus.req_ready, 0);
    chk("rst.resp_valid", bus.resp_valid, 0);
    chk("rst.resp_err", bus.resp_err, 0);
    chk("rst.resp_rdata", bus.resp_rdata, 0);
    chk("rst.mem_en", bus.mem_en, 0);
    chk("rst.mem_we", bus.mem_we, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.mem_din", bus.mem_din, 0);
    bus.req_valid = 1'b0;
    rstb = 1'b0;

    //                we    sz    uns   addr          wdata         err   rdata         en    we     ma      din
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1, 4'hF, 11'd4, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 4'h0, 11'd4, 32'h0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0080, 1'b0, 32'h0000_0000, 1'b1, 4'h8, 11'd4, 32'h8080_8080};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b1, 4'h0, 11'd4, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0080, 1'b1, 4'h0, 11'd4, 32'h0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b1, 4'hC, 11'd8, 32'h1234_1234};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 4'h0, 11'd8, 32'h0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 4'h0, 11'd0, 32'h0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 4'h0, 11'd0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 4'h0, 11'd0, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0031, 32'h0000_ABCD, 1'b1, 32'h0000_0000, 1'b0, 4'h0, 11'd0, 32'h0};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 4'h0, 11'd12, 32'h0};
`else
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'h80AD_BEEF, 1'b1, 4'h0, 11'd4, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0031, 32'h0000_ABCD, 1'b0, 32'h0000_0000, 1'b1, 4'h3, 11'd12, 32'hABCD_ABCD};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'hFFFF_ABCD, 1'b1, 4'h0, 11'd12, 32'h0};
`endif
    tbl[12] = '{1'b0, 2'd0, 1'b1, 32'h0000_1FFF, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 4'h0, 11'd2047, 32'h0};

    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd);
      chk($sformatf("v%0d.req_ready", i), o_rdy, 1);
      chk($sformatf("v%0d.mem_en", i), o_en, tbl[i].x_en);
      chk($sformatf("v%0d.latency", i), o_lat, (tbl[i].x_en && !tbl[i].we) ? 2 : 1);
      chk($sformatf("v%0d.resp_err", i), o_err, tbl[i].x_err);
      chk($sformatf("v%0d.resp_rdata", i), o_rd, tbl[i].x_rd);
      if (tbl[i].x_en) begin
        chk($sformatf("v%0d.mem_we", i), o_we, tbl[i].x_we);
        chk($sformatf("v%0d.mem_addr", i), o_ma, tbl[i].x_ma);
        if (tbl[i].we) chk($sformatf("v%0d.mem_din", i), o_din, tbl[i].x_din);
      end
      if (tbl[i].we && !tbl[i].x_err) mdl_store(tbl[i].addr, tbl[i].sz, tbl[i].wd);
    end

    // Backpressure: response must hold and no new request may be taken
    @(negedge clka);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
    @(negedge clka);
    bus.req_we = 1'b1; bus.req_wdata = 32'h5555_AAAA;
    w = 0;
    while (bus.resp_valid !== 1'b1 && w < 8) begin
      @(negedge clka);
      w++;
    end
    chk("bp.wait", w, 1);
    hold_rd = bus.resp_rdata; hold_err = bus.resp_err;
    chk("bp.rdata", hold_rd, mdl_load(32'h10, 2'd2, 1'b0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clka);
      #1;
      chk($sformatf("bp%0d.resp_valid", c), bus.resp_valid, 1);
      chk($sformatf("bp%0d.resp_rdata", c), bus.resp_rdata, hold_rd);
      chk($sformatf("bp%0d.resp_err", c), bus.resp_err, hold_err);
      chk($sformatf("bp%0d.req_ready", c), bus.req_ready, 0);
      chk($sformatf("bp%0d.mem_en", c), bus.mem_en, 0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clka);
    bus.resp_ready = 1'b0;

    // Reset while the load sits in RD: it must vanish without a response
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h10;
    @(negedge clka);
    bus.req_valid = 1'b0;
    rstb = 1'b1;
    #1;
    chk("rrd.resp_valid0", bus.resp_valid, 0);
    chk("rrd.req_ready0", bus.req_ready, 0);
    @(negedge clka);
    #1;
    chk("rrd.resp_valid1", bus.resp_valid, 0);
    chk("rrd.req_ready1", bus.req_ready, 0);
    chk("rrd.mem_en", bus.mem_en, 0);
    rstb = 1'b0;
    #1;
    chk("rrd.req_ready_after", bus.req_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      #1;
      chk($sformatf("rrd%0d.no_resp", c), bus.resp_valid, 0);
    end

    // Random traffic against the byte-array model
    for (int k = 0; k < 400; k++) begin
      r_we = 1'($urandom_range(0, 1));
      r_s  = 2'($urandom_range(0, 3));
      r_u  = 1'($urandom_range(0, 1));
      r_wd = $urandom;
      case ($urandom_range(0, 9))
        0:       r_a = 32'h0000_2000 + 32'($urandom_range(0, 15));
        1:       r_a = $urandom;
        2:       r_a = 32'h0000_1FF0 + 32'($urandom_range(0, 15));
        default: r_a = 32'($urandom_range(0, 63));
      endcase
      r_f = mdl_fault(r_a, r_s);
      r_x = (r_we || r_f) ? 32'd0 : mdl_load(r_a, r_s, r_u);
      do_req(r_we, r_s, r_u, r_a, r_wd);
      chk($sformatf("r%0d.mem_en", k), o_en, !r_f);
      chk($sformatf("r%0d.resp_err", k), o_err, r_f);
      chk($sformatf("r%0d.resp_rdata", k), o_rd, r_x);
      chk($sformatf("r%0d.latency", k), o_lat, (!r_f && !r_we) ? 2 : 1);
      if (!r_f) chk($sformatf("r%0d.mem_addr", k), o_ma, 32'(ea_of(r_a, r_s) >> 2));
      if (r_we && !r_f) mdl_store(r_a, r_s, r_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store front end for the on-chip dual-port SRAM. It accepts one CPU data-memory request at a time over a valid/ready handshake and converts byte, half-word and word accesses into word address, byte-lane write enables and replicated write data. It absorbs the SRAM's one-cycle read latency and returns aligned, sign- or zero-extended load data with an error flag. It sits between the CPU execute/memory stage and SRAM port B; port A stays with instruction fetch.

## Interface
- `RAM_DEPTH`, default 2048: number of 32-bit SRAM words; must match the SRAM instance.
- `ADDR_W`, default clog2(RAM_DEPTH) = 11: SRAM word-address width.
- `BASE_ADDR`, default 32'h0000_0000: byte address of SRAM word 0. Must be 4-byte aligned.

Ports:
- `clka` in 1: clock, shared with the SRAM.
- `rstb` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed on `resp_valid && resp_ready`.
- `resp_rdata` out 32: load result. 0 for stores and errors.
- `resp_err` out 1: access fault (range, size, or misalignment).
- `mem_en` out 1: SRAM port enable.
- `mem_we` out 4: SRAM byte write enables.
- `mem_addr` out ADDR_W: SRAM word address.
- `mem_din` out 32: SRAM write data.
- `mem_dout` in 32: SRAM read data, valid one cycle after `mem_en`.

## Operation
- **Address split.** Offset = `req_addr - BASE_ADDR`. Word index = offset[ADDR_W+1:2]. Lane = offset[1:0].
- **Fault checks.** An access is a fault when:
  - `req_addr < BASE_ADDR`, or offset ≥ 4·RAM_DEPTH;
  - `req_size` = 3;
  - it is misaligned (see Configuration).
- **Fault handling.** A faulting request never asserts `mem_en`. It responds with `resp_err` = 1 and `resp_rdata` = 0.
- **Store enables and data.**
  - Byte: `mem_we` = 4'b0001 << lane; `mem_din` = {4{wdata[7:0]}}.
  - Half: `mem_we` = 4'b0011 << lane; `mem_din` = {2{wdata[15:0]}}.
  - Word: `mem_we` = 4'b1111; `mem_din` = wdata.
- **Load data.** `mem_we` = 0. The field is `mem_dout >> 8·lane`, truncated to the access size, then sign- or zero-extended to 32 bits.
- **State machine** (3 states):
  - IDLE: `req_ready` = 1.
    - On accept of a legal load: drive `mem_*` combinationally from the request and go to RD.
    - On accept of a legal store or any fault: drive `mem_*` for a legal store only; load the response register and go to RSP.
  - RD: capture the extracted `mem_dout` into the response register, then go to RSP.
  - RSP: `resp_valid` = 1. On `resp_ready`, go to IDLE.
- Lane, size and unsigned are registered at accept for use in RD.
- `mem_en` is high only during an accepted legal request. `mem_*` outputs are 0 otherwise.

## Timing
- **Reset values.** While `rstb` = 1 and on the edge it is sampled:
  - state = IDLE;
  - `req_ready` = 0, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0;
  - `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0.
- **Load latency.** Accept in cycle N, SRAM read at the end of N, capture at the end of N+1, `resp_valid` from N+2.
- **Store and fault latency.** Accept in cycle N, write at the end of N, `resp_valid` from N+1.
- **No pipelining.** `req_ready` = 0 in RD and RSP, so there is one outstanding request at most. The next request is accepted no earlier than the cycle after the response handshake.
- **Response hold.** `resp_valid`, `resp_rdata` and `resp_err` stay stable until the `resp_ready` handshake.
- **Reset mid-operation.** A store already written at an edge stays written. A load in RD is discarded. No response is produced after reset.
- **Write collisions.** A same-word write on port A in the same cycle is resolved by the SRAM. This block does not arbitrate it.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - half with lane[0] ≠ 0 is a fault;
  - word with lane ≠ 0 is a fault.
- Not defined:
  - half forces lane[0] = 0;
  - word forces lane = 0;
  - the access proceeds without an error. Range and size faults remain in both builds.

## Structure
- Package `lsu_pkg` holds:
  - the size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum IDLE, RD, RSP;
  - a lane-mask function.
- Sub-module `lsu_lane_align`: purely combinational. It performs store byte-lane steering and load extraction/extension, and is instantiated once.

## Test plan
- **Word round trip.** Store word 32'hDEAD_BEEF at 0x10, then load word at 0x10. Expect `mem_we` = 4'hF, `mem_addr` = 4, and the store response at N+1. Expect the load response at N+2 with `resp_rdata` = 32'hDEAD_BEEF and `resp_err` = 0.
- **Byte store then signed/unsigned loads.** Store byte 8'h80 at 0x13: expect `mem_we` = 4'b1000 and `mem_din` = 32'h8080_8080. Load byte signed at 0x13: expect 32'hFFFF_FF80. Load byte unsigned at 0x13: expect 32'h0000_0080.
- **Half-word in the upper lane.** Store half 16'h1234 at 0x22: expect `mem_we` = 4'b1100. Load half unsigned at 0x22: expect 32'h0000_1234.
- **Fault responses.** Load at 4·RAM_DEPTH = 0x2000: expect `mem_en` never high and `resp_err` = 1 at N+1. Repeat with `req_size` = 3. Repeat with a word at 0x11: expect `resp_err` = 1 with the macro, and an access at word 4 without it.
- **Backpressure and reset.** Hold `resp_ready` = 0 for 5 cycles: expect `resp_*` stable and `req_ready` = 0. Then assert `rstb` during RD: expect `resp_valid` = 0 and `req_ready` = 0 during reset, and `req_ready` = 1 in the first cycle after reset.
